// File: rtl/proc_control_unit_if.sv
// Control bus between the instruction sequencer (slave) and the datapath (master).
// The datapath supplies Run/DIN; the sequencer returns the bus selects and enables.
interface proc_control_unit_if;
   logic        Run;
   logic [15:0] DIN;
   logic        IRin;
   logic [7:0]  Rin;
   logic [7:0]  Rout;
   logic        Ain;
   logic        Gin;
   logic        Gout;
   logic        DINout;
   logic        AddSub;
   logic        Done;

   modport master (
      output Run, DIN,
      input  IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done
   );

   modport slave (
      input  Run, DIN,
      output IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done
   );
endinterface

// File: rtl/proc_control_unit.sv
// Instruction sequencer: fetches a 9-bit instruction and steps T0..T3 to drive datapath controls.
//   state | meaning
//   T0    | fetch: IRin follows Run, wait for a start request
//   T1    | mv/mvi/undefined complete here; add/sub move Rx into A
//   T2    | add/sub: Ry onto bus, ALU result into G
//   T3    | add/sub: G written back to Rx
module proc_control_unit (
   input  logic                 Clock,
   input  logic                 Resetn,
   proc_control_unit_if.slave   bus
);
   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

   step_t      step_q, step_d;
   logic [8:0] ir_q;

   logic       ir_in, ain, gin, gout, din_out, add_sub, done;
   logic [7:0] rin, rout;

   logic [2:0] op, rx, ry;
   logic       is_arith;
   logic       unused_din;

   assign op         = ir_q[8:6];
   assign rx         = ir_q[5:3];
   assign ry         = ir_q[2:0];
   assign is_arith   = (op == 3'b010) || (op == 3'b011);
   assign unused_din = ^bus.DIN[15:9];

   function automatic logic [7:0] onehot(input logic [2:0] n);
      return 8'b1000_0000 >> n;
   endfunction

   always_comb begin
      step_d  = T0;
      ir_in   = 1'b0;
      rin     = 8'h00;
      rout    = 8'h00;
      ain     = 1'b0;
      gin     = 1'b0;
      gout    = 1'b0;
      din_out = 1'b0;
      add_sub = 1'b0;
      done    = 1'b0;
      case (step_q)
         T0: begin
            ir_in  = bus.Run;
            step_d = bus.Run ? T1 : T0;
         end
         T1: begin
            case (op)
               3'b000: begin
                  rout = onehot(ry);
                  rin  = onehot(rx);
                  done = 1'b1;
               end
               3'b001: begin
                  din_out = 1'b1;
                  rin     = onehot(rx);
                  done    = 1'b1;
               end
               3'b010, 3'b011: begin
                  rout   = onehot(rx);
                  ain    = 1'b1;
                  step_d = T2;
               end
               default: done = 1'b1;
            endcase
         end
         T2: begin
            if (is_arith) begin
               rout    = onehot(ry);
               gin     = 1'b1;
               add_sub = op[0];
               step_d  = T3;
            end
         end
         T3: begin
            if (is_arith) begin
               gout = 1'b1;
               rin  = onehot(rx);
               done = 1'b1;
            end
         end
         default: step_d = T0;
      endcase
   end

   // Outputs are gated by reset so IRin cannot follow Run while the sequencer is held.
   assign bus.IRin   = Resetn & ir_in;
   assign bus.Rin    = Resetn ? rin  : 8'h00;
   assign bus.Rout   = Resetn ? rout : 8'h00;
   assign bus.Ain    = Resetn & ain;
   assign bus.Gin    = Resetn & gin;
   assign bus.Gout   = Resetn & gout;
   assign bus.DINout = Resetn & din_out;
   assign bus.AddSub = Resetn & add_sub;
   assign bus.Done   = Resetn & done;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         step_q <= T0;
         ir_q   <= 9'b0;
      end else begin
         step_q <= step_d;
         if (ir_in) ir_q <= bus.DIN[8:0];
      end
   end
endmodule

// File: doc/proc_control_unit.md
# proc_control_unit

Instruction sequencer for the 16-bit processor datapath. It captures a 9-bit instruction from DIN, decodes it, and steps through up to four time steps (T0–T3). Each step drives the bus-source selects (Rout, Gout, DINout) consumed by the bus multiplexer, plus the register, accumulator and ALU enables. Done pulses once per completed instruction.

## Interface
- No parameters.
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  start request; sampled only in T0.
- DIN  in  16  external data; DIN[8:0] is the instruction word `III XXX YYY`.
- IRin  out  1  IR load strobe (also loads the internal IR copy).
- Rin  out  8  register write enables, one-hot; R0 = bit 7 … R7 = bit 0.
- Rout  out  8  bus source select, one-hot; same bit mapping as Rin (R0 = 8'b1000_0000).
- Ain  out  1  load A from bus.
- Gin  out  1  load G from ALU.
- Gout  out  1  drive G onto bus.
- DINout  out  1  drive DIN onto bus.
- AddSub  out  1  ALU op: 0 = add, 1 = subtract.
- Done  out  1  instruction complete, one-cycle pulse.

## Operation
**Registers**
- 2-bit step counter, encoded T0 = 0, T1 = 1, T2 = 2, T3 = 3.
- 9-bit IR, loaded from DIN[8:0] on a clock edge where IRin = 1.
- Decode:
  - III = IR[8:6]
  - X = IR[5:3], destination
  - Y = IR[2:0], source
- onehot(n) = 8'b1000_0000 >> n.

**Outputs**
- Outputs are combinational from (step, IR, Run).
- Every output not listed for a step is 0.

**T0 (fetch)**
- IRin = Run.
- Next step = Run ? T1 : T0.

**III = 000, mv Rx,Ry**
- T1: Rout = onehot(Y), Rin = onehot(X), Done = 1. Next: T0.

**III = 001, mvi Rx,#D** (immediate on DIN in T1)
- T1: DINout = 1, Rin = onehot(X), Done = 1. Next: T0.

**III = 010 add, 011 sub**
- T1: Rout = onehot(X), Ain = 1. Next: T2.
- T2: Rout = onehot(Y), Gin = 1, AddSub = III[0]. Next: T3.
- T3: Gout = 1, Rin = onehot(X), Done = 1. Next: T0.

**III = 100–111 (undefined)**
- T1: Done = 1 only; no register or bus activity. Next: T0.

**Invariants**
- At most one of {Rout ≠ 0, Gout, DINout} is active per cycle.
- Rin and Rout are each zero or one-hot.
- In T0 no bus source is selected; the bus value is don't-care.
- AddSub is 0 in every step except sub T2.
- Run is ignored in T1–T3.
- X = Y is legal: mv R3,R3 is a 1-step no-op write; add R2,R2 doubles R2.

## Timing
- Reset (Resetn low, asynchronous):
  - step = T0, IR = 9'b0.
  - All outputs forced 0 while Resetn = 0, including IRin regardless of Run.
- Reset mid-instruction aborts with no Done. The first cycle after release is T0.
- Latency from the Run-sampled edge to the Done cycle:
  - mv, mvi, undefined: Done in the first cycle after the fetch edge.
  - add/sub: Done in the third cycle after the fetch edge.
- Back-to-back execution:
  - Run held high makes the cycle after Done a T0 with IRin = 1, so the next fetch needs no idle gap.
  - Throughput: mv/mvi 2 cycles, add/sub 4 cycles.
- Done is high for exactly one cycle per instruction. It never asserts in T0.
- IR is stable from T1 through the end of the instruction. DIN changes after fetch do not affect decode.

## Test plan
- **Reset:** Resetn = 0 with Run = 1, DIN = 9'o010 → all outputs 0 and IRin = 0. Release reset → T0, IRin = 1 in the same cycle.
- **mvi R0,#5:** DIN = 9'o100 at fetch, then DIN = 5 → T1 shows DINout = 1, Rin = 8'b1000_0000, Done = 1. Next cycle is T0.
- **mv R7,R0:** DIN = 9'o070 → T1 shows Rout = 8'b1000_0000, Rin = 8'b0000_0001, Done = 1.
- **add R1,R2** (9'o212):
  - T1: Rout = 8'b0100_0000, Ain = 1.
  - T2: Rout = 8'b0010_0000, Gin = 1, AddSub = 0.
  - T3: Gout = 1, Rin = 8'b0100_0000, Done = 1.
- **sub R3,R4** (9'o334) with Run held high:
  - T2 shows AddSub = 1.
  - After Done, T0 shows IRin = 1 with no gap.
  - Opcode 9'o700 gives Done in T1 with all other outputs 0.
- **Reset during add:** assert Resetn low while in T2 → outputs go to 0 immediately and Done never pulses. After release, T0 with Run = 0 holds idle with all outputs 0.
